// File: rtl/spi_aes_pkg.sv
// Shared types and constants for the SPI-to-AES frame assembler.
// Pure definitions: no latency, no backpressure.
package spi_aes_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KEY     = 3'd1,
    S_DATA    = 3'd2,
    S_HOLD    = 3'd3,
    S_WAIT_SS = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  localparam logic [3:0] NK4 = 4'd4;
  localparam logic [3:0] NK6 = 4'd6;
  localparam logic [3:0] NK8 = 4'd8;

  localparam int BLOCK_W = 128;

  function automatic logic nk_legal(input logic [3:0] nk);
    return (nk == NK4) || (nk == NK6) || (nk == NK8);
  endfunction

endpackage

// File: rtl/spi_aes_frame_assembler_spi_shift_collector.sv
// MSB-first shift register with bit counter; one bit per enabled shift cycle.
// No backpressure: the caller decides when to shift or clear.
module spi_shift_collector #(
  parameter int W = 128
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         clear,
  input  logic         bit_in,
  input  logic [W-1:0] mask,
  output logic [W-1:0] dat,
  output logic [8:0]   cnt
);

  // clear together with shift starts a fresh word holding only bit_in
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dat <= '0;
      cnt <= '0;
    end else if (shift_en && clear) begin
      dat <= {{(W-1){1'b0}}, bit_in} & mask;
      cnt <= 9'd1;
    end else if (shift_en) begin
      dat <= {dat[W-2:0], bit_in} & mask;
      cnt <= cnt + 9'd1;
    end else if (clear) begin
      dat <= '0;
      cnt <= '0;
    end
  end

endmodule

// File: rtl/spi_aes_frame_assembler.sv
// Deserialises one SS-framed MOSI transfer into an AES key then a data block; valid 1 cycle after last bit.
// data_valid holds with data_out stable until data_ready; Enable=0 freezes everything.
module spi_aes_frame_assembler #(
  parameter int MAX_NK  = 8,
  parameter int BLOCK_W = spi_aes_pkg::BLOCK_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  Enable,
  input  logic [3:0]            Nk,
  input  logic                  ss,
  input  logic                  mosi,
  output logic [MAX_NK*32-1:0]  key_out,
  output logic                  key_valid,
  output logic [BLOCK_W-1:0]    data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [3:0]            nk_latched,
  output logic                  frame_err,
  output logic                  busy
);
  import spi_aes_pkg::*;

  localparam int KW = MAX_NK * 32;

  state_t          state, state_nx;
  logic            key_shift, key_clr, dat_shift, dat_clr;
  logic            kv_nx, dv_nx, fe_nx;
  logic [3:0]      nk_nx;
  logic [3:0]      nk_sel;
  logic [KW-1:0]   key_mask;
  logic [8:0]      key_cnt, dat_cnt, key_last;

  // IDLE masks with the live Nk because nk_latched only updates on that edge
  assign nk_sel   = (state == S_IDLE) ? Nk : nk_latched;
  assign key_mask = ~({KW{1'b1}} << {nk_sel, 5'd0});
  assign key_last = {nk_latched, 5'd0} - 9'd1;
  assign busy     = (state != S_IDLE);

  spi_shift_collector #(.W(KW)) u_key (
    .clock    (clock),
    .reset    (reset),
    .shift_en (Enable & key_shift),
    .clear    (Enable & key_clr),
    .bit_in   (mosi),
    .mask     (key_mask),
    .dat      (key_out),
    .cnt      (key_cnt)
  );

  spi_shift_collector #(.W(BLOCK_W)) u_dat (
    .clock    (clock),
    .reset    (reset),
    .shift_en (Enable & dat_shift),
    .clear    (Enable & dat_clr),
    .bit_in   (mosi),
    .mask     ({BLOCK_W{1'b1}}),
    .dat      (data_out),
    .cnt      (dat_cnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      key_valid  <= 1'b0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      nk_latched <= 4'd0;
    end else if (Enable) begin
      state      <= state_nx;
      key_valid  <= kv_nx;
      data_valid <= dv_nx;
      frame_err  <= fe_nx;
      nk_latched <= nk_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    key_shift = 1'b0;
    key_clr   = 1'b0;
    dat_shift = 1'b0;
    dat_clr   = 1'b0;
    kv_nx     = key_valid;
    dv_nx     = data_valid;
    fe_nx     = 1'b0;
    nk_nx     = nk_latched;
    case (state)
      S_IDLE: begin
        if (!ss) begin
          nk_nx   = Nk;
          key_clr = 1'b1;
          dat_clr = 1'b1;
          kv_nx   = 1'b0;
          if (nk_legal(Nk)) begin
            key_shift = 1'b1;
            state_nx  = S_KEY;
          end else begin
            fe_nx    = 1'b1;
            state_nx = S_ERR;
          end
        end
      end
      S_KEY, S_DATA: begin
        if (ss) begin
          // early ss release: the partial frame is dropped
          fe_nx    = 1'b1;
          kv_nx    = 1'b0;
          key_clr  = 1'b1;
          dat_clr  = 1'b1;
          state_nx = S_IDLE;
        end else if (state == S_KEY) begin
          key_shift = 1'b1;
          if (key_cnt == key_last) begin
            kv_nx    = 1'b1;
            state_nx = S_DATA;
          end
        end else begin
          dat_shift = 1'b1;
          if (dat_cnt == 9'(BLOCK_W - 1)) begin
            dv_nx    = 1'b1;
            state_nx = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (data_valid && data_ready) begin
          dv_nx    = 1'b0;
          state_nx = ss ? S_IDLE : S_WAIT_SS;
        end
      end
      S_WAIT_SS: begin
        if (ss) state_nx = S_IDLE;
      end
      S_ERR: begin
        kv_nx   = 1'b0;
        dv_nx   = 1'b0;
        key_clr = 1'b1;
        dat_clr = 1'b1;
        if (ss) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_aes_frame_assembler.sv
// Directed bench for spi_aes_frame_assembler: frames of each key length, stalls, aborts, bad Nk, Enable gaps, reset.
module tb_spi_aes_frame_assembler;

  logic         clock = 1'b0;
  logic         reset;
  logic         en;
  logic [3:0]   nk;
  logic         ss;
  logic         mosi;
  logic         data_ready;
  logic [255:0] key_out;
  logic         key_valid;
  logic [127:0] data_out;
  logic         data_valid;
  logic [3:0]   nk_latched;
  logic         frame_err;
  logic         busy;

  int checks = 0;
  int failures = 0;

  int           cur_nk;
  logic [255:0] cur_key;
  logic [127:0] cur_dat;
  logic [127:0] held;

  always #5 clock = ~clock;

  spi_aes_frame_assembler #(.MAX_NK(8), .BLOCK_W(128)) dut (
    .clock      (clock),
    .reset      (reset),
    .Enable     (en),
    .Nk         (nk),
    .ss         (ss),
    .mosi       (mosi),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .nk_latched (nk_latched),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic frame_bit(input int i);
    if (i < cur_nk * 32) return cur_key[cur_nk*32-1-i];
    return cur_dat[127-(i-cur_nk*32)];
  endfunction

  task automatic drive_bits(input int from, input int to);
    for (int i = from; i < to; i++) begin
      ss   = 1'b0;
      mosi = frame_bit(i);
      step();
    end
  endtask

  // drives a complete frame and leaves the DUT in HOLD
  task automatic full_frame(input string tag);
    int kb;
    kb = cur_nk * 32;
    nk = 4'(cur_nk);
    drive_bits(0, kb - 1);
    chk({tag, "_kv_early"}, 256'(key_valid), 256'd0);
    drive_bits(kb - 1, kb);
    chk({tag, "_kv"}, 256'(key_valid), 256'd1);
    chk({tag, "_key"}, key_out, cur_key);
    chk({tag, "_nkl"}, 256'(nk_latched), 256'(cur_nk));
    drive_bits(kb, kb + 127);
    chk({tag, "_dv_early"}, 256'(data_valid), 256'd0);
    drive_bits(kb + 127, kb + 128);
    chk({tag, "_dv"}, 256'(data_valid), 256'd1);
    chk({tag, "_dat"}, 256'(data_out), 256'(cur_dat));
  endtask

  task automatic accept_and_release(input string tag);
    data_ready = 1'b1;
    ss = 1'b1;
    step();
    chk({tag, "_dv_drop"}, 256'(data_valid), 256'd0);
    chk({tag, "_idle"}, 256'(busy), 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b1; nk = 4'd4; ss = 1'b1; mosi = 1'b0; data_ready = 1'b1;
    #12;
    chk("rst_key", key_out, 256'd0);
    chk("rst_flags", 256'({key_valid, data_valid, frame_err, busy}), 256'd0);
    chk("rst_dat", 256'(data_out), 256'd0);
    chk("rst_nkl", 256'(nk_latched), 256'd0);
    reset = 1'b0;
    step();

    // Nk=4, ready high: data_valid lasts one cycle
    cur_nk  = 4;
    cur_key = 256'h000102030405060708090A0B0C0D0E0F;
    cur_dat = 128'h00112233445566778899AABBCCDDEEFF;
    full_frame("nk4");
    accept_and_release("nk4");
    chk("nk4_kv_keep", 256'(key_valid), 256'd1);

    // Nk=8, ten stall cycles with ss raised during HOLD
    cur_nk  = 8;
    cur_key = 256'h0123456789ABCDEFFEDCBA98765432100F1E2D3C4B5A69788796A5B4C3D2E1F0;
    cur_dat = 128'hDEADBEEFCAFEBABE0123456789ABCDEF;
    data_ready = 1'b0;
    full_frame("nk8");
    held = data_out;
    ss = 1'b1;
    for (int c = 0; c < 10; c++) begin
      mosi = 1'($urandom);
      step();
      chk("nk8_stall", 256'({busy, data_valid, data_out}), 256'({1'b1, 1'b1, cur_dat}));
    end
    chk("nk8_held", 256'(held), 256'(cur_dat));
    accept_and_release("nk8");

    // Nk=6 aborted after 100 data bits, then a clean Nk=6 frame
    cur_nk  = 6;
    cur_key = 256'h112233445566778899AABBCCDDEEFF000F0E0D0C0B0A0908;
    cur_dat = 128'hA5A5A5A55A5A5A5AC3C3C3C33C3C3C3C;
    nk = 4'd6;
    drive_bits(0, 192 + 100);
    ss = 1'b1;
    step();
    chk("ab_err", 256'(frame_err), 256'd1);
    chk("ab_kv", 256'(key_valid), 256'd0);
    chk("ab_busy", 256'(busy), 256'd0);
    chk("ab_dat", 256'(data_out), 256'd0);
    step();
    chk("ab_err_pulse", 256'(frame_err), 256'd0);
    full_frame("nk6");
    accept_and_release("nk6");

    // illegal Nk=5
    nk = 4'd5; ss = 1'b0;
    step();
    chk("bad_err", 256'(frame_err), 256'd1);
    chk("bad_nkl", 256'(nk_latched), 256'd5);
    chk("bad_busy", 256'(busy), 256'd1);
    for (int c = 0; c < 5; c++) begin
      mosi = 1'($urandom);
      step();
      chk("bad_hold", 256'({frame_err, key_valid, data_valid, busy}), 256'b0001);
    end
    ss = 1'b1;
    step();
    chk("bad_idle", 256'(busy), 256'd0);
    chk("bad_nkl_keep", 256'(nk_latched), 256'd5);

    // Enable low for 7 cycles mid-key
    cur_nk  = 4;
    cur_key = 256'hFFEEDDCCBBAA99887766554433221100;
    cur_dat = 128'h0F0F0F0FF0F0F0F01234567887654321;
    nk = 4'd4;
    data_ready = 1'b1;
    drive_bits(0, 40);
    en = 1'b0;
    for (int c = 0; c < 7; c++) begin
      mosi = 1'($urandom);
      ss = 1'b0;
      step();
    end
    en = 1'b1;
    drive_bits(40, 127);
    chk("en_kv_early", 256'(key_valid), 256'd0);
    drive_bits(127, 128);
    chk("en_kv", 256'(key_valid), 256'd1);
    chk("en_key", key_out, cur_key);
    drive_bits(128, 256);
    chk("en_dv", 256'(data_valid), 256'd1);
    chk("en_dat", 256'(data_out), 256'(cur_dat));
    accept_and_release("en");

    // asynchronous reset at data bit 64, then a normal frame
    cur_key = 256'h00112233445566778899AABBCCDDEEFF;
    cur_dat = 128'hFEDCBA98765432100123456789ABCDEF;
    drive_bits(0, 128 + 64);
    #2 reset = 1'b1;
    #1;
    chk("ar_key", key_out, 256'd0);
    chk("ar_dat", 256'(data_out), 256'd0);
    chk("ar_flags", 256'({key_valid, data_valid, frame_err, busy, nk_latched}), 256'd0);
    reset = 1'b0;
    ss = 1'b1;
    step();
    cur_key = 256'h55AA55AA00FF00FF1234ABCD9876FEDC;
    full_frame("ar");
    accept_and_release("ar");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
